// File: rtl/dmux_4way_if.sv
// Producer/consumer bus for dmux_4way: one input word with select, four gated output channels.
interface dmux_4way_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] in;
  logic [1:0]       sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;

  modport master (
    output in, sel, in_valid, out_ready,
    input  in_ready, out0, out1, out2, out3, out_valid
  );

  modport slave (
    input  in, sel, in_valid, out_ready,
    output in_ready, out0, out1, out2, out3, out_valid
  );
endinterface

// File: rtl/dmux_4way.sv
// Registered 1-to-4 demultiplexer with per-channel one-entry output registers.
// Optional per-channel saturating accept counters when DMUX4WAY_STATS_EN is defined.
module dmux_4way #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef DMUX4WAY_STATS_EN
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3,
`endif
  dmux_4way_if.slave       bus
);

  logic [WIDTH-1:0] r_data  [4];
  logic [3:0]       r_valid;
  logic [WIDTH-1:0] w_out   [4];
  logic             w_in_ready;
  logic             w_accept;
  logic [3:0]       w_load;
  logic [3:0]       w_drain;

  // Readiness depends only on the selected channel, so a blocked channel never stalls the others.
  assign w_in_ready = ~r_valid[bus.sel] | bus.out_ready[bus.sel];
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_load     = {4{w_accept}} & (4'b0001 << bus.sel);
  assign w_drain    = r_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int k = 0; k < 4; k++) r_data[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_load[k]) begin
          r_data[k]  <= bus.in;
          r_valid[k] <= 1'b1;
        end else if (w_drain[k]) begin
          r_data[k]  <= '0;
          r_valid[k] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_out[k] = r_valid[k] ? r_data[k] : '0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.out0      = w_out[0];
  assign bus.out1      = w_out[1];
  assign bus.out2      = w_out[2];
  assign bus.out3      = w_out[3];

`ifdef DMUX4WAY_STATS_EN
  logic [CNT_W-1:0] r_cnt [4];

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (clr_cnt) begin
          r_cnt[k] <= '0;
        end else if (w_load[k] && (r_cnt[k] != {CNT_W{1'b1}})) begin
          r_cnt[k] <= r_cnt[k] + 1'b1;
        end
      end
    end
  end

  assign cnt0 = r_cnt[0];
  assign cnt1 = r_cnt[1];
  assign cnt2 = r_cnt[2];
  assign cnt3 = r_cnt[3];
`endif

endmodule

// File: tb/tb_dmux_4way.sv
// Scoreboard bench for dmux_4way: drivers push expected words per channel, a negedge monitor
// compares every presented word and pops on handshake.
module tb_dmux_4way;
  localparam int unsigned W  = 1;
  localparam int unsigned CW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmux_4way_if #(.WIDTH(W)) bus ();

`ifdef DMUX4WAY_STATS_EN
  logic          clr_cnt;
  logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;
`endif

  dmux_4way #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef DMUX4WAY_STATS_EN
    .clr_cnt (clr_cnt),
    .cnt0    (cnt0),
    .cnt1    (cnt1),
    .cnt2    (cnt2),
    .cnt3    (cnt3),
`endif
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] q0[$], q1[$], q2[$], q3[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input logic [W-1:0] v);
    case (k)
      0: q0.push_back(v);
      1: q1.push_back(v);
      2: q2.push_back(v);
      default: q3.push_back(v);
    endcase
  endtask

  function automatic int qsz(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [W-1:0] qfront(input int k);
    case (k)
      0: return q0[0];
      1: return q1[0];
      2: return q2[0];
      default: return q3[0];
    endcase
  endfunction

  task automatic qpop(input int k);
    logic [W-1:0] tmp;
    case (k)
      0: tmp = q0.pop_front();
      1: tmp = q1.pop_front();
      2: tmp = q2.pop_front();
      default: tmp = q3.pop_front();
    endcase
  endtask

  function automatic logic [W-1:0] dout(input int k);
    case (k)
      0: return bus.out0;
      1: return bus.out1;
      2: return bus.out2;
      default: return bus.out3;
    endcase
  endfunction

  function automatic logic [3:0] outs_packed();
    return {bus.out3[0], bus.out2[0], bus.out1[0], bus.out0[0]};
  endfunction

  // Monitor: every presented word must equal the head of its channel queue.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.out_valid[k]) begin
          if (qsz(k) == 0) begin
            check($sformatf("unexpected_word_ch%0d", k), 32'(bus.out_valid[k]), 32'd0);
          end else begin
            check($sformatf("data_ch%0d", k), 32'(dout(k)), 32'(qfront(k)));
            if (bus.out_ready[k]) qpop(k);
          end
        end else begin
          check($sformatf("gated_zero_ch%0d", k), 32'(dout(k)), 32'd0);
        end
      end
    end
  end

  // Offer one word; bounded wait for in_ready, then the expected word is queued.
  task automatic xfer(input int s, input logic [W-1:0] d);
    bit done = 0;
    bus.in       = d;
    bus.sel      = 2'(s);
    bus.in_valid = 1'b1;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        push(s, d);
        done = 1;
      end
    end
    if (!done) check("xfer_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in        = '0;
    bus.sel       = 2'b00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
`ifdef DMUX4WAY_STATS_EN
    clr_cnt = 1'b0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_outs", 32'(outs_packed()), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("post_rst_outs", 32'(outs_packed()), 32'h0);

    // Routing sweep
    bus.out_ready = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      xfer(s, 1'b0);
      check($sformatf("route0_valid_s%0d", s), 32'(bus.out_valid), 32'(4'b0001 << s));
      check($sformatf("route0_outs_s%0d", s), 32'(outs_packed()), 32'h0);
    end
    for (int s = 0; s < 4; s++) begin
      xfer(s, 1'b1);
      check($sformatf("route1_valid_s%0d", s), 32'(bus.out_valid), 32'(4'b0001 << s));
      check($sformatf("route1_outs_s%0d", s), 32'(outs_packed()), 32'(4'b0001 << s));
    end
    @(posedge clk);
    #1;

    // Backpressure
    bus.out_ready = 4'b0000;
    xfer(2, 1'b1);
    check("bp_valid", 32'(bus.out_valid), 32'h4);
    check("bp_out2", 32'(bus.out2), 32'h1);
    bus.in       = 1'b0;
    bus.sel      = 2'b10;
    bus.in_valid = 1'b1;
    #1;
    check("bp_in_ready_blocked", 32'(bus.in_ready), 32'h0);
    @(posedge clk);
    #1;
    check("bp_hold_out2", 32'(bus.out2), 32'h1);
    check("bp_hold_valid", 32'(bus.out_valid), 32'h4);
    bus.sel = 2'b01;
    #1;
    check("bp_in_ready_switch", 32'(bus.in_ready), 32'h1);
    bus.in_valid = 1'b0;
    xfer(1, 1'b1);
    check("bp_valid_two", 32'(bus.out_valid), 32'h6);
    check("bp_outs_two", 32'(outs_packed()), 32'h6);
    bus.out_ready = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    check("bp_drained", 32'(bus.out_valid), 32'h0);

    // Full throughput on channel 3
    bus.out_ready = 4'b1000;
    bus.sel       = 2'b11;
    for (int i = 0; i < 3; i++) begin
      logic [W-1:0] d;
      d            = (i == 1) ? 1'b0 : 1'b1;
      bus.in       = d;
      bus.in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("tp_in_ready_%0d", i), 32'(bus.in_ready), 32'h1);
      if (bus.in_ready) push(3, d);
      @(posedge clk);
      #1;
      check($sformatf("tp_out3_%0d", i), 32'(bus.out3), 32'(d));
      check($sformatf("tp_valid_%0d", i), 32'(bus.out_valid), 32'h8);
    end
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Mid-operation reset
    bus.out_ready = 4'b0000;
    xfer(0, 1'b1);
    xfer(1, 1'b0);
    xfer(2, 1'b1);
    xfer(3, 1'b1);
    check("full_valid", 32'(bus.out_valid), 32'hF);
    check("full_outs", 32'(outs_packed()), 32'hD);
    #2;
    rst_n = 1'b0;
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    #1;
    check("midrst_valid", 32'(bus.out_valid), 32'h0);
    check("midrst_outs", 32'(outs_packed()), 32'h0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'h1);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef DMUX4WAY_STATS_EN
    bus.out_ready = 4'b1111;
    for (int i = 0; i < 5; i++) xfer(0, 1'b1);
    check("cnt0_sat", 32'(cnt0), 32'h3);
    check("cnt1_zero", 32'(cnt1), 32'h0);
    check("cnt2_zero", 32'(cnt2), 32'h0);
    check("cnt3_zero", 32'(cnt3), 32'h0);
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    check("cnt_clr", 32'({cnt3, cnt2, cnt1, cnt0}), 32'h0);
`endif

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) check($sformatf("queue_empty_ch%0d", k), 32'(qsz(k)), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dmux_4way.md
Name: dmux_4way

Overview:
Registered 1-to-4 demultiplexer with valid/ready flow control. Each accepted input word is steered by a 2-bit select to exactly one of four output channels. Unselected or idle channels drive zero data. The block sits between a single producer and four independent consumers, and each channel has its own one-entry output register.

Parameters:
WIDTH, 1, data width of the input and of each output channel.
CNT_W, 16, width of the per-channel transfer counters (used only with the optional feature).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in  input  WIDTH  input data word.
sel  input  2  channel select: 00→out0, 01→out1, 10→out2, 11→out3.
in_valid  input  1  producer has a word on in/sel.
in_ready  output  1  block accepts the word this cycle.
out0, out1, out2, out3  output  WIDTH each  channel data; zero whenever that channel is not valid.
out_valid  output  4  bit k set when channel k holds a word.
out_ready  input  4  bit k set when consumer k takes the word this cycle.

Behaviour:
- Reset (asynchronous, rst_n=0): all channel registers are cleared, so out_valid=4'b0000 and out0..out3 are all zero. in_ready follows its combinational equation, so it reads 1.
- in_ready = ~out_valid[sel] | out_ready[sel]. It is combinational and depends only on the selected channel.
- Accept: when in_valid and in_ready are both high at a rising edge, the channel register selected by sel loads in and its valid bit is set. Latency is 1 cycle, so the word is visible on outN and out_valid[N] on the next cycle.
- Drain: when out_valid[k] and out_ready[k] are both high at an edge and channel k is not being loaded, out_valid[k] clears and its data register is cleared to zero.
- Simultaneous drain and load on the same channel: the new word replaces the old one and valid stays 1. This gives full throughput of one word per cycle per channel.
- Non-selected channels are unaffected by an accept. Their held words stay stable until drained, whatever the values of in and sel.
- Data gating: outN = stored word when out_valid[N]=1, else all zeros. An invalid channel never shows stale data.
- in_valid=0: no state change except drains.
- sel and in may change freely while in_valid=0. They are sampled only at an accept.
- Backpressure: if the selected channel is full and its out_ready=0, in_ready=0 and the producer must hold in/sel/in_valid stable.
- A blocked channel does not block other channels. Changing sel to a free channel re-asserts in_ready in the same cycle.
- Reset asserted mid-operation discards all held words immediately, with no partial output.

Optional Feature:
Macro DMUX4WAY_STATS_EN.
- Defined:
  - Adds output ports cnt0, cnt1, cnt2, cnt3, each CNT_W wide.
  - cntN increments by 1 on every accept into channel N.
  - Counters saturate at all-ones and do not wrap.
  - Counters reset to 0 on rst_n=0.
  - Adds input clr_cnt (1 bit), which synchronously clears all counters to 0. clr_cnt takes priority over a same-cycle increment.
- Undefined: the counter and clr_cnt ports and their logic are absent; datapath behaviour is identical.

Test Plan:
1. Reset: rst_n=0 → out_valid=0000, out0..out3=0, in_ready=1. Release reset with in_valid=0 → outputs unchanged.
2. Routing sweep (WIDTH=1, out_ready=1111):
   - in=0 with sel=00,01,10,11 → the selected channel's out_valid pulses one cycle later and all data outputs are 0.
   - in=1 with sel=00,01,10,11 → only the selected outN=1 one cycle later; the other three outputs stay 0.
3. Backpressure: out_ready=0000; accept in=1,sel=10 → out2=1, out_valid=0100.
   - Next cycle with sel=10 → in_ready=0 and out2 is held.
   - Switch to sel=01 → in_ready=1; the accept sets out_valid=0110.
4. Full throughput: out_ready[3]=1, in_valid=1, sel=11, in alternating 1,0,1 → out3 follows with 1-cycle latency and in_ready stays 1.
5. Mid-operation reset: out_valid=1111, pulse rst_n low between clock edges → all outputs go 0 immediately, without waiting for a clock edge.
6. (DMUX4WAY_STATS_EN, CNT_W=2) Five accepts on sel=00 → cnt0=3 (saturated), others 0. clr_cnt=1 for one cycle → all counters 0.
